priority_code_decoder: RTL and testbench

PRIORITY_CODE_DECODER -- requirements
Module: priority_code_decoder

---
 rtl/priority_code_decoder.sv | 143 ++++++++++++++
 tb/tb_priority_code_decoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/priority_code_decoder.sv
// priority_code_decoder
//
// Decodes an 8-bit priority code into a registered one-hot beat with a
// single-entry valid/ready output stage.
//   8'h00..8'h0F -> out_onehot = 1 << code[3:0], out_none = 0
//   8'hF0        -> out_onehot = 0,              out_none = 1
//   anything else is illegal: consumed, no beat produced, err set (sticky).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   in_code is offered
//   in_ready   block can accept in_code (!out_valid || out_ready)
//   in_code    encoded priority word
//   out_valid  decoded beat is held
//   out_ready  downstream accepts the beat
//   out_onehot one-hot decode of the index
//   out_none   beat carries the all-zeros code
//   err        sticky illegal-code flag
//   dec_count  wrapping count of decoded non-none beats
//   accum_clr  synchronous clear of out_accum     (PRIO_DEC_ACCUM_EN only)
//   out_accum  OR of every decoded one-hot        (PRIO_DEC_ACCUM_EN only)
//
// Build option: define PRIO_DEC_ACCUM_EN to add the one-hot accumulator.

module priority_code_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_code,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_onehot,
  output logic        out_none,
  output logic        err,
  output logic [7:0]  dec_count
`ifdef PRIO_DEC_ACCUM_EN
  ,
  input  logic        accum_clr,
  output logic [15:0] out_accum
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] onehot_q, onehot_d;
  logic        none_q, none_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        hs;
  logic        code_idx;
  logic        code_none;
  logic        legal_hs;
  logic [15:0] dec_onehot;

  assign in_ready   = (state_q == EMPTY) || out_ready;
  assign hs         = in_valid && in_ready;
  assign code_idx   = (in_code[7:4] == 4'h0);
  assign code_none  = (in_code == 8'hF0);
  assign legal_hs   = hs && (code_idx || code_none);
  assign dec_onehot = code_idx ? (16'h0001 << in_code[3:0]) : 16'h0000;

  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    none_d   = none_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    if (hs && !(code_idx || code_none)) begin
      err_d = 1'b1;
    end
    if (hs && code_idx) begin
      cnt_d = cnt_q + 8'd1;
    end

    // A legal handshake always loads (EMPTY, or FULL being drained this
    // cycle). Otherwise a drained FULL stage empties and zeroes its fields
    // so the outputs read as zero whenever out_valid is low.
    if (legal_hs) begin
      state_d  = FULL;
      onehot_d = dec_onehot;
      none_d   = code_none;
    end else if (state_q == FULL && out_ready) begin
      state_d  = EMPTY;
      onehot_d = 16'h0000;
      none_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      onehot_q <= 16'h0000;
      none_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      none_q   <= none_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid  = (state_q == FULL);
  assign out_onehot = onehot_q;
  assign out_none   = none_q;
  assign err        = err_q;
  assign dec_count  = cnt_q;

`ifdef PRIO_DEC_ACCUM_EN
  logic [15:0] accum_q, accum_d;

  // Clear wins over a same-cycle OR.
  always_comb begin
    accum_d = accum_q;
    if (accum_clr) begin
      accum_d = 16'h0000;
    end else if (legal_hs) begin
      accum_d = accum_q | dec_onehot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accum_q <= 16'h0000;
    end else begin
      accum_q <= accum_d;
    end
  end

  assign out_accum = accum_q;
`endif

endmodule

// File: tb/tb_priority_code_decoder.sv
module tb_priority_code_decoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_code;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_onehot;
  logic        out_none;
  logic        err;
  logic [7:0]  dec_count;
`ifdef PRIO_DEC_ACCUM_EN
  logic        accum_clr;
  logic [15:0] out_accum;
`endif

  int checks;
  int failures;
  int exp_cnt;

  priority_code_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_none   (out_none),
    .err        (err),
    .dec_count  (dec_count)
`ifdef PRIO_DEC_ACCUM_EN
    ,
    .accum_clr  (accum_clr),
    .out_accum  (out_accum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_code = 8'h05; out_ready = 1'b1;
`ifdef PRIO_DEC_ACCUM_EN
    accum_clr = 1'b0;
`endif
    tick(); tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_onehot !== 16'h0000) begin failures++; $display("FAIL rst_onehot got=%h exp=0000", out_onehot); end
    checks++; if (out_none !== 1'b0) begin failures++; $display("FAIL rst_none got=%b exp=0", out_none); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
    checks++; if (dec_count !== 8'h00) begin failures++; $display("FAIL rst_count got=%h exp=00", dec_count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
`ifdef PRIO_DEC_ACCUM_EN
    checks++; if (out_accum !== 16'h0000) begin failures++; $display("FAIL rst_accum got=%h exp=0000", out_accum); end
`endif
    in_valid = 1'b0;
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_decode();
    logic [7:0]  codes [3];
    logic [15:0] exp   [3];
    codes = '{8'h00, 8'h05, 8'h0F};
    exp   = '{16'h0001, 16'h0020, 16'h8000};
    out_ready = 1'b1;
    in_valid = 1'b1; in_code = codes[0];
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL dec_latency got=%b exp=0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      in_code = codes[i];
      tick();
      exp_cnt++;
      checks++; if (out_valid !== 1'b1 || out_onehot !== exp[i] || out_none !== 1'b0)
        begin failures++; $display("FAIL dec_beat%0d got=%b/%h/%b exp=1/%h/0", i, out_valid, out_onehot, out_none, exp[i]); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || out_onehot !== 16'h0000) begin failures++; $display("FAIL dec_drain got=%b/%h exp=0/0000", out_valid, out_onehot); end
    checks++; if (dec_count !== 8'd3) begin failures++; $display("FAIL dec_count got=%0d exp=3", dec_count); end
  endtask

  task automatic test_none();
    in_valid = 1'b1; in_code = 8'hF0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_none !== 1'b1 || out_onehot !== 16'h0000)
      begin failures++; $display("FAIL none_beat got=%b/%b/%h exp=1/1/0000", out_valid, out_none, out_onehot); end
    checks++; if (dec_count !== 8'(exp_cnt)) begin failures++; $display("FAIL none_count got=%0d exp=%0d", dec_count, exp_cnt); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_none !== 1'b0) begin failures++; $display("FAIL none_drain got=%b/%b exp=0/0", out_valid, out_none); end
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; in_code = 8'h3A; out_ready = 1'b1;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ill_err_before got=%b exp=0", err); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ill_no_beat got=%b exp=0", out_valid); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill_err got=%b exp=1", err); end
    checks++; if (dec_count !== 8'(exp_cnt)) begin failures++; $display("FAIL ill_count got=%0d exp=%0d", dec_count, exp_cnt); end
    in_valid = 1'b1; in_code = 8'h01;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_cnt++;
    end
    in_valid = 1'b0;
    tick();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill_err_sticky got=%b exp=1", err); end
    checks++; if (dec_count !== 8'(exp_cnt)) begin failures++; $display("FAIL ill_count20 got=%0d exp=%0d", dec_count, exp_cnt); end
    // Illegal code while FULL and draining empties the stage.
    in_valid = 1'b1; in_code = 8'h02;
    tick();
    exp_cnt++;
    in_code = 8'h77;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_onehot !== 16'h0000) begin failures++; $display("FAIL ill_full_drain got=%b/%h exp=0/0000", out_valid, out_onehot); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_code = 8'h07; out_ready = 1'b0;
    tick();
    exp_cnt++;
    in_code = 8'h02;
    for (int i = 0; i < 5; i++) begin
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_onehot !== 16'h0080)
        begin failures++; $display("FAIL bp_hold%0d got=%b/%b/%h exp=0/1/0080", i, in_ready, out_valid, out_onehot); end
      tick();
    end
    checks++; if (dec_count !== 8'(exp_cnt)) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", dec_count, exp_cnt); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready got=%b exp=1", in_ready); end
    tick();
    exp_cnt++;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_onehot !== 16'h0004) begin failures++; $display("FAIL bp_reload got=%b/%h exp=1/0004", out_valid, out_onehot); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_wrap();
    int n;
    n = 256 - exp_cnt;
    in_valid = 1'b1; in_code = 8'h0C; out_ready = 1'b1;
    for (int i = 0; i < n - 1; i++) tick();
    checks++; if (dec_count !== 8'hFF) begin failures++; $display("FAIL wrap_ff got=%h exp=ff", dec_count); end
    tick();
    in_valid = 1'b0;
    exp_cnt = 0;
    checks++; if (dec_count !== 8'h00) begin failures++; $display("FAIL wrap_00 got=%h exp=00", dec_count); end
    tick();
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_code = 8'h09; out_ready = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_onehot !== 16'h0200) begin failures++; $display("FAIL ar_full got=%b/%h exp=1/0200", out_valid, out_onehot); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_onehot !== 16'h0000 || out_none !== 1'b0)
      begin failures++; $display("FAIL ar_clear got=%b/%h/%b exp=0/0000/0", out_valid, out_onehot, out_none); end
    checks++; if (err !== 1'b0 || dec_count !== 8'h00) begin failures++; $display("FAIL ar_ctrl got=%b/%h exp=0/00", err, dec_count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ar_in_ready got=%b exp=1", in_ready); end
    in_code = 8'h03; out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0 || dec_count !== 8'h00) begin failures++; $display("FAIL ar_ignore got=%b/%h exp=0/00", out_valid, dec_count); end
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ar_no_pulse got=%b exp=0", out_valid); end
    rst = 1'b1;
    #2;
    in_valid = 1'b1; in_code = 8'h06;
    rst = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_onehot !== 16'h0040 || dec_count !== 8'h01)
      begin failures++; $display("FAIL ar_first_hs got=%b/%h/%h exp=1/0040/01", out_valid, out_onehot, dec_count); end
    tick();
  endtask

`ifdef PRIO_DEC_ACCUM_EN
  task automatic test_accum();
    out_ready = 1'b1;
    accum_clr = 1'b1;
    tick();
    accum_clr = 1'b0;
    checks++; if (out_accum !== 16'h0000) begin failures++; $display("FAIL acc_clr0 got=%h exp=0000", out_accum); end
    in_valid = 1'b1; in_code = 8'h01;
    tick();
    in_code = 8'h04;
    tick();
    in_code = 8'hF0;
    tick();
    in_valid = 1'b0;
    checks++; if (out_accum !== 16'h0012) begin failures++; $display("FAIL acc_or got=%h exp=0012", out_accum); end
    in_valid = 1'b1; in_code = 8'h00; accum_clr = 1'b1;
    tick();
    in_valid = 1'b0; accum_clr = 1'b0;
    checks++; if (out_accum !== 16'h0000) begin failures++; $display("FAIL acc_clr_prec got=%h exp=0000", out_accum); end
    checks++; if (out_valid !== 1'b1 || out_onehot !== 16'h0001) begin failures++; $display("FAIL acc_beat got=%b/%h exp=1/0001", out_valid, out_onehot); end
    tick();
  endtask
`endif

  initial begin
    checks = 0; failures = 0; exp_cnt = 0;
    rst = 1'b1; in_valid = 1'b0; in_code = 8'h00; out_ready = 1'b0;
`ifdef PRIO_DEC_ACCUM_EN
    accum_clr = 1'b0;
`endif
    test_reset();
    test_decode();
    test_none();
    test_illegal();
    test_backpressure();
    test_wrap();
    test_async_reset();
`ifdef PRIO_DEC_ACCUM_EN
    test_accum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
